axi3_mem_responder: RTL and testbench

//  AXI3 slave memory model answering the 256-bit AXI3 master port of an exit pipeline (33b addr, 4b len, 2b lock, no ID).

---
 rtl/axi3_resp_pkg.sv | 26 ++
 rtl/axi3_resp_mem.sv | 35 +++
 rtl/axi3_mem_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi3_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_resp_pkg.sv
// rtl/axi3_resp_pkg.sv - shared response/burst encodings, FSM state types and burst legality helper
package axi3_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] FULL_SIZE = 3'd5;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    // Bursts that cannot be honoured at all: their beats are still transferred but never touch the RAM.
    function automatic logic burst_cfg_err(input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len);
        logic wrap_bad;
        wrap_bad = (burst == BURST_WRAP) &&
                   !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        return (size != FULL_SIZE) || (burst == 2'b11) || wrap_bad;
    endfunction

endpackage

// File: rtl/axi3_resp_mem.sv
// rtl/axi3_resp_mem.sv - 1W1R byte-enabled RAM, read-first, registered read port, contents not reset
module axi3_resp_mem
#(
    parameter int DATA_W     = 256,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi3_mem_responder.sv
// rtl/axi3_mem_responder.sv - AXI3 256-bit slave memory model with independent write/read FSMs
// Optional: define AXI3_RESP_DECERR_EN to answer DECERR for addresses beyond the RAM.
module axi3_mem_responder
    import axi3_resp_pkg::*;
#(
    parameter int ADDR_W         = 33,
    parameter int DATA_W         = 256,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [3:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic [1:0]          s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [3:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic [1:0]          s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);

    // Next beat address; WRAP keeps the bits above the (len+1)-beat window and wraps those inside it.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'({len, {LSB{1'b1}}});
        if (burst == BURST_INCR) return (a | ADDR_W'(STRB_W - 1)) + ADDR_W'(1);
        if (burst == BURST_WRAP) return (a & ~mask) | ((a + ADDR_W'(STRB_W)) & mask);
        return a;
    endfunction

    logic aw_dec, ar_dec;
`ifdef AXI3_RESP_DECERR_EN
    assign aw_dec = |(s_axi_awaddr >> (LSB + MEM_DEPTH_LOG2));
    assign ar_dec = |(s_axi_araddr >> (LSB + MEM_DEPTH_LOG2));
`else
    assign aw_dec = 1'b0;
    assign ar_dec = 1'b0;
`endif

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    wr_state_t         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic [1:0]        wr_burst_q, wr_burst_d;
    logic              wr_cfg_err_q, wr_cfg_err_d, wr_last_err_q, wr_last_err_d, wr_dec_q, wr_dec_d;

    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]        rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
    logic [1:0]        rd_burst_q, rd_burst_d;
    logic              rd_cfg_err_q, rd_cfg_err_d, rd_dec_q, rd_dec_d;

    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;

    axi3_resp_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (wr_addr_q[LSB +: MEM_DEPTH_LOG2]),
        .wdata (s_axi_wdata),
        .wstrb (s_axi_wstrb),
        .re    (mem_re),
        .raddr (rd_addr_q[LSB +: MEM_DEPTH_LOG2]),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_addr_d     = wr_addr_q;
        wr_len_d      = wr_len_q;
        wr_cnt_d      = wr_cnt_q;
        wr_burst_d    = wr_burst_q;
        wr_cfg_err_d  = wr_cfg_err_q;
        wr_last_err_d = wr_last_err_q;
        wr_dec_d      = wr_dec_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        mem_we        = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                s_axi_awready = aresetn;
                if (s_axi_awvalid) begin
                    wr_addr_d     = s_axi_awaddr;
                    wr_len_d      = s_axi_awlen;
                    wr_burst_d    = s_axi_awburst;
                    wr_cnt_d      = 4'd0;
                    wr_cfg_err_d  = burst_cfg_err(s_axi_awsize, s_axi_awburst, s_axi_awlen);
                    wr_last_err_d = 1'b0;
                    wr_dec_d      = aw_dec;
                    wr_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_we    = !(wr_cfg_err_q || wr_dec_q);
                    wr_cnt_d  = wr_cnt_q + 4'd1;
                    wr_addr_d = next_addr(wr_addr_q, wr_len_q, wr_burst_q);
                    if (s_axi_wlast != (wr_cnt_q == wr_len_q)) wr_last_err_d = 1'b1;
                    // Beat count, not wlast, closes the burst so a bad wlast cannot desync the channel.
                    if (wr_cnt_q == wr_len_q) wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (wr_dec_q)                           s_axi_bresp = RESP_DECERR;
                else if (wr_cfg_err_q || wr_last_err_q) s_axi_bresp = RESP_SLVERR;
                if (s_axi_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q    <= W_IDLE;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            wr_cnt_q      <= '0;
            wr_burst_q    <= '0;
            wr_cfg_err_q  <= 1'b0;
            wr_last_err_q <= 1'b0;
            wr_dec_q      <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_addr_q     <= wr_addr_d;
            wr_len_q      <= wr_len_d;
            wr_cnt_q      <= wr_cnt_d;
            wr_burst_q    <= wr_burst_d;
            wr_cfg_err_q  <= wr_cfg_err_d;
            wr_last_err_q <= wr_last_err_d;
            wr_dec_q      <= wr_dec_d;
        end
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rd_addr_d     = rd_addr_q;
        rd_len_d      = rd_len_q;
        rd_cnt_d      = rd_cnt_q;
        rd_burst_d    = rd_burst_q;
        rd_cfg_err_d  = rd_cfg_err_q;
        rd_dec_d      = rd_dec_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rresp   = RESP_OKAY;
        s_axi_rdata   = '0;
        mem_re        = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                s_axi_arready = aresetn;
                if (s_axi_arvalid) begin
                    rd_addr_d    = s_axi_araddr;
                    rd_len_d     = s_axi_arlen;
                    rd_burst_d   = s_axi_arburst;
                    rd_cnt_d     = 4'd0;
                    rd_cfg_err_d = burst_cfg_err(s_axi_arsize, s_axi_arburst, s_axi_arlen);
                    rd_dec_d     = ar_dec;
                    rd_state_d   = R_FETCH;
                end
            end
            R_FETCH: begin
                mem_re     = 1'b1;
                rd_state_d = R_DATA;
            end
            R_DATA: begin
                // RAM output register only loads in R_FETCH, so rdata stays put while stalled.
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (rd_cnt_q == rd_len_q);
                if (rd_dec_q)          s_axi_rresp = RESP_DECERR;
                else if (rd_cfg_err_q) s_axi_rresp = RESP_SLVERR;
                if (!(rd_dec_q || rd_cfg_err_q)) s_axi_rdata = mem_rdata;
                if (s_axi_rready) begin
                    if (rd_cnt_q == rd_len_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + 4'd1;
                        rd_addr_d  = next_addr(rd_addr_q, rd_len_q, rd_burst_q);
                        rd_state_d = R_FETCH;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_q   <= R_IDLE;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            rd_cnt_q     <= '0;
            rd_burst_q   <= '0;
            rd_cfg_err_q <= 1'b0;
            rd_dec_q     <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_burst_q   <= rd_burst_d;
            rd_cfg_err_q <= rd_cfg_err_d;
            rd_dec_q     <= rd_dec_d;
        end
    end

endmodule

// File: tb/tb_axi3_mem_responder.sv
// tb/tb_axi3_mem_responder.sv - randomized self-checking bench for axi3_mem_responder against a word-level memory model
module tb_axi3_mem_responder;

    localparam int TMO = 50;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [32:0]  awaddr = '0, araddr = '0;
    logic [3:0]   awlen = '0, arlen = '0;
    logic [2:0]   awsize = 3'd5, arsize = 3'd5;
    logic [1:0]   awburst = 2'b01, arburst = 2'b01;
    logic [1:0]   awlock = '0, arlock = '0;
    logic [3:0]   awcache = '0, arcache = '0, awqos = '0, arqos = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 1'b0, arvalid = 1'b0, awready, arready;
    logic [255:0] wdata = '0;
    logic [31:0]  wstrb = '0;
    logic         wlast = 1'b0, wvalid = 1'b0, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready = 1'b0;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready = 1'b0;

    always #5 aclk = ~aclk;

    axi3_mem_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot), .s_axi_awqos(awqos),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot), .s_axi_arqos(arqos),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [255:0] mem_m [1024];
    logic [255:0] wd [16];
    logic [31:0]  ws [16];
    logic [255:0] rd_data [16];
    logic [1:0]   rd_resp [16];
    logic         rd_last [16];
    logic [1:0]   last_bresp;

    // Word visited on beat k of a burst, straight from the burst-type definitions.
    function automatic int beat_idx(input logic [32:0] a, input int len, input logic [1:0] burst, input int k);
        int w, n;
        w = int'(a[14:5]);
        n = len + 1;
        if (burst == 2'b01) return (w + k) % 1024;
        if (burst == 2'b10) return (w - (w % n)) + ((w % n) + k) % n;
        return w;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [32:0] a, input int len, input logic [2:0] size,
                                            input logic [1:0] burst, input logic last_bad);
`ifdef AXI3_RESP_DECERR_EN
        if (a[32:15] != '0) return 2'b11;
`endif
        if (size != 3'd5 || burst == 2'b11 || last_bad) return 2'b10;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
        return 2'b00;
    endfunction

    // bad_beat flips wlast on that beat (-1: wlast correct); bstall holds bready low that many cycles.
    task automatic axi_write(input logic [32:0] a, input int len, input logic [2:0] size, input logic [1:0] burst,
                             input int bad_beat, input int bstall);
        int t;
        logic [1:0] pre, er;
        pre = exp_resp(a, len, size, burst, 1'b0);
        er  = exp_resp(a, len, size, burst, (bad_beat >= 0) && (bad_beat <= len));
        awaddr = a; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TMO) begin @(negedge aclk); t++; end
        check("aw_hs", 256'(t < TMO), 256'(1));
        @(negedge aclk);
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wdata = wd[k]; wstrb = ws[k]; wlast = (k == len) ^ (k == bad_beat); wvalid = 1'b1;
            t = 0;
            while (!wready && t < TMO) begin @(negedge aclk); t++; end
            check("w_hs", 256'(t < TMO), 256'(1));
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_closed", 256'(wready), 256'(0));
        if (pre == 2'b00) begin
            for (int k = 0; k <= len; k++) begin
                for (int b = 0; b < 32; b++) begin
                    if (ws[k][b]) mem_m[beat_idx(a, len, burst, k)][8*b +: 8] = wd[k][8*b +: 8];
                end
            end
        end
        bready = (bstall == 0);
        t = 0;
        while (!bvalid && t < TMO) begin @(negedge aclk); t++; end
        check("b_hs", 256'(t < TMO), 256'(1));
        last_bresp = bresp;
        repeat (bstall) begin
            @(negedge aclk);
            check("b_hold", 256'({bvalid, bresp}), 256'({1'b1, last_bresp}));
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("b_drop", 256'(bvalid), 256'(0));
        check("bresp", 256'(last_bresp), 256'(er));
    endtask

    task automatic axi_read(input logic [32:0] a, input int len, input logic [2:0] size, input logic [1:0] burst,
                            input int rstall);
        int t;
        logic [1:0] er;
        er = exp_resp(a, len, size, burst, 1'b0);
        araddr = a; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin @(negedge aclk); t++; end
        check("ar_hs", 256'(t < TMO), 256'(1));
        @(negedge aclk);
        arvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            t = 0;
            while (!rvalid && t < TMO) begin @(negedge aclk); t++; end
            check("r_gap", 256'(t), 256'(1));
            rd_data[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast;
            repeat ((k == 0) ? rstall : int'($urandom_range(0, 1))) begin
                @(negedge aclk);
                check("r_hold", 256'({rvalid, rresp, rlast}), 256'({1'b1, rd_resp[k], rd_last[k]}));
                check("r_hold_data", rdata, rd_data[k]);
            end
            rready = 1'b1;
            @(negedge aclk);
            rready = 1'b0;
            check("r_drop", 256'(rvalid), 256'(0));
            check("rresp", 256'(rd_resp[k]), 256'(er));
            check("rlast", 256'(rd_last[k]), 256'(k == len));
            check("rdata", rd_data[k], (er == 2'b00) ? mem_m[beat_idx(a, len, burst, k)] : 256'(0));
        end
    endtask

    initial begin : main
        int len;
        logic [1:0] burst;
        logic [2:0] size;
        logic [32:0] a;
        logic [1:0] dec_exp;

        repeat (3) @(negedge aclk);
        check("rst_ready", 256'({awready, arready, wready}), 256'(0));
        check("rst_valid", 256'({bvalid, rvalid, rlast}), 256'(0));
        check("rst_resp", 256'({bresp, rresp}), 256'(0));
        check("rst_rdata", rdata, 256'(0));
        aresetn = 1'b1;
        @(negedge aclk);

        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) begin
                wd[k] = {8{$urandom}}; ws[k] = '1;
            end
            axi_write(33'(blk * 512), 15, 3'd5, 2'b01, -1, 0);
        end

        for (int k = 0; k < 4; k++) begin wd[k] = 256'(k + 1); ws[k] = '1; end
        axi_write(33'h40, 3, 3'd5, 2'b01, -1, 0);
        axi_read(33'h40, 3, 3'd5, 2'b01, 0);
        for (int k = 0; k < 4; k++) begin
            check("incr_data", rd_data[k], 256'(k + 1));
            check("incr_last", 256'(rd_last[k]), 256'(k == 3));
        end

        wd[0] = '1; ws[0] = '1;
        axi_write(33'h100, 0, 3'd5, 2'b01, -1, 0);
        wd[0] = '0; ws[0] = 32'h0000_000F;
        axi_write(33'h100, 0, 3'd5, 2'b01, -1, 0);
        axi_read(33'h100, 0, 3'd5, 2'b01, 0);
        check("strb_data", rd_data[0], {{224{1'b1}}, 32'h0});

        for (int k = 0; k < 4; k++) begin wd[k] = 256'(16 + k); ws[k] = '1; end
        axi_write(33'h0, 3, 3'd5, 2'b01, -1, 0);
        axi_read(33'h60, 3, 3'd5, 2'b10, 0);
        check("wrap_b0", rd_data[0], 256'(19));
        check("wrap_b1", rd_data[1], 256'(16));
        check("wrap_b3", rd_data[3], 256'(18));

        for (int k = 0; k < 3; k++) begin wd[k] = 256'(10 + k); ws[k] = '1; end
        axi_write(33'h80, 2, 3'd5, 2'b00, -1, 0);
        axi_read(33'h80, 0, 3'd5, 2'b01, 0);
        check("fixed_last", rd_data[0], 256'(12));

        for (int k = 0; k < 4; k++) begin wd[k] = 256'h dead; ws[k] = '1; end
        axi_write(33'h0, 3, 3'd2, 2'b01, -1, 0);
        check("size_bresp", 256'(last_bresp), 256'(2'b10));
        axi_read(33'h0, 3, 3'd5, 2'b01, 0);
        check("size_nowrite", rd_data[1], 256'(17));

        for (int k = 0; k < 4; k++) begin wd[k] = 256'(32 + k); ws[k] = '1; end
        axi_write(33'h0, 3, 3'd5, 2'b01, 1, 10);
        check("wlast_bresp", 256'(last_bresp), 256'(2'b10));
        axi_read(33'h0, 3, 3'd5, 2'b01, 10);
        check("wlast_written", rd_data[2], 256'(34));

        araddr = 33'h0; arlen = 4'd7; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        @(negedge aclk);
        check("mid_rvalid", 256'(rvalid), 256'(1));
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid_rst_rvalid", 256'({rvalid, arready}), 256'(0));
        aresetn = 1'b1;
        @(negedge aclk);
        axi_read(33'h40, 3, 3'd5, 2'b01, 0);

`ifdef AXI3_RESP_DECERR_EN
        dec_exp = 2'b11;
`else
        dec_exp = 2'b00;
`endif
        axi_read(33'h1_0000_0000, 1, 3'd5, 2'b01, 0);
        check("dec_resp", 256'(rd_resp[1]), 256'(dec_exp));

        for (int it = 0; it < 60; it++) begin
            len   = int'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) burst = 2'b11;
            size  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd5;
            a     = 33'($urandom_range(0, 47)) * 33'd32 + 33'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = a | (33'($urandom_range(1, 255)) << 25);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++) begin wd[k] = {8{$urandom}}; ws[k] = $urandom; end
                axi_write(a, len, size, burst, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1,
                          int'($urandom_range(0, 2)));
            end else begin
                axi_read(a, len, size, burst, int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
